// File: rtl/gpu_ram_arbiter_if.sv
// ---------------------------------------------------------------------------
// gpu_ram_arbiter_if : Z80, graphics-engine and RAM-port signal bundle.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface gpu_ram_arbiter_if #(
  parameter int ADDR_BITS = 20
);
  logic                 z80_wr_ena;
  logic                 z80_rd_req;
  logic [ADDR_BITS-1:0] z80_addr;
  logic [7:0]           z80_wdata;
  logic [7:0]           z80_rData;
  logic                 z80_rd_rdy;
  logic                 z80_overrun;

  logic                 gfx_req;
  logic                 gfx_wr;
  logic [ADDR_BITS-1:0] gfx_addr;
  logic [7:0]           gfx_wdata;
  logic                 gfx_ack;
  logic [7:0]           gfx_rData;
  logic                 gfx_rd_rdy;

  logic [ADDR_BITS-1:0] ram_addr;
  logic [7:0]           ram_wdata;
  logic                 ram_wena;
  logic                 ram_rd_req;
  logic [7:0]           ram_rdata;

  modport slave (
    input  z80_wr_ena, z80_rd_req, z80_addr, z80_wdata,
    output z80_rData, z80_rd_rdy, z80_overrun,
    input  gfx_req, gfx_wr, gfx_addr, gfx_wdata,
    output gfx_ack, gfx_rData, gfx_rd_rdy,
    output ram_addr, ram_wdata, ram_wena, ram_rd_req,
    input  ram_rdata
  );

  modport master (
    output z80_wr_ena, z80_rd_req, z80_addr, z80_wdata,
    input  z80_rData, z80_rd_rdy, z80_overrun,
    output gfx_req, gfx_wr, gfx_addr, gfx_wdata,
    input  gfx_ack, gfx_rData, gfx_rd_rdy,
    input  ram_addr, ram_wdata, ram_wena, ram_rd_req,
    output ram_rdata
  );
endinterface

`default_nettype wire

// File: rtl/gpu_ram_arbiter.sv
// ---------------------------------------------------------------------------
// gpu_ram_arbiter : shares the GPU RAM host port between the Z80 bridge and
// the graphics engine. Macro GPU_RAM_ARB_RR_EN selects round-robin. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gpu_ram_arbiter #(
  parameter int ADDR_BITS  = 20,
  parameter int RD_LATENCY = 2
) (
  input  logic             GPU_CLK,
  input  logic             reset,
  gpu_ram_arbiter_if.slave bus
);

  logic                  z80_pulse;
  logic                  z80_elig;
  logic                  gfx_elig;
  logic                  grant_z80;
  logic                  grant_gfx;
  logic                  pend_valid;
  logic                  pend_wr;
  logic [ADDR_BITS-1:0]  pend_addr;
  logic [7:0]            pend_wdata;
  logic                  pend_load;
  logic                  drop;
  logic                  cand_wr;
  logic [ADDR_BITS-1:0]  cand_addr;
  logic [7:0]            cand_wdata;
  logic                  issue_src;
  logic [RD_LATENCY-1:0] tag_valid;
  logic [RD_LATENCY-1:0] tag_src;
  logic [RD_LATENCY:0]   tag_valid_in;
  logic [RD_LATENCY:0]   tag_src_in;

  assign z80_pulse = bus.z80_wr_ena | bus.z80_rd_req;
  assign z80_elig  = pend_valid | z80_pulse;
  // Masking the ack cycle stops a still-held request being issued twice.
  assign gfx_elig  = bus.gfx_req & ~bus.gfx_ack;

`ifdef GPU_RAM_ARB_RR_EN
  logic last_z80;

  assign grant_z80 = z80_elig & (~gfx_elig | ~last_z80);

  always_ff @(posedge GPU_CLK) begin
    if (reset) begin
      last_z80 <= 1'b0;
    end else if (grant_z80) begin
      last_z80 <= 1'b1;
    end else if (grant_gfx) begin
      last_z80 <= 1'b0;
    end
  end
`else
  assign grant_z80 = z80_elig;
`endif

  assign grant_gfx = gfx_elig & ~grant_z80;

  always_comb begin
    cand_wr    = bus.z80_wr_ena;
    cand_addr  = bus.z80_addr;
    cand_wdata = bus.z80_wdata;
    if (pend_valid) begin
      cand_wr    = pend_wr;
      cand_addr  = pend_addr;
      cand_wdata = pend_wdata;
    end
  end

  // A pulse is held when it cannot bypass, or refills a slot being issued now.
  assign pend_load = z80_pulse & (pend_valid ? grant_z80 : ~grant_z80);
  assign drop      = z80_pulse & pend_valid & ~grant_z80;

  assign tag_valid_in = {tag_valid, bus.ram_rd_req};
  assign tag_src_in   = {tag_src, issue_src};

  always_ff @(posedge GPU_CLK) begin
    if (reset) begin
      pend_valid      <= 1'b0;
      pend_wr         <= 1'b0;
      pend_addr       <= '0;
      pend_wdata      <= '0;
      issue_src       <= 1'b0;
      tag_valid       <= '0;
      tag_src         <= '0;
      bus.ram_addr    <= '0;
      bus.ram_wdata   <= '0;
      bus.ram_wena    <= 1'b0;
      bus.ram_rd_req  <= 1'b0;
      bus.gfx_ack     <= 1'b0;
      bus.z80_rData   <= '0;
      bus.z80_rd_rdy  <= 1'b0;
      bus.z80_overrun <= 1'b0;
      bus.gfx_rData   <= '0;
      bus.gfx_rd_rdy  <= 1'b0;
    end else begin
      if (pend_load) begin
        pend_wr    <= bus.z80_wr_ena;
        pend_addr  <= bus.z80_addr;
        pend_wdata <= bus.z80_wdata;
      end
      pend_valid <= pend_load | (pend_valid & ~grant_z80);

      if (drop | (bus.z80_wr_ena & bus.z80_rd_req)) begin
        bus.z80_overrun <= 1'b1;
      end

      bus.ram_wena   <= 1'b0;
      bus.ram_rd_req <= 1'b0;
      bus.gfx_ack    <= 1'b0;
      if (grant_z80) begin
        bus.ram_addr   <= cand_addr;
        bus.ram_wdata  <= cand_wdata;
        bus.ram_wena   <= cand_wr;
        bus.ram_rd_req <= ~cand_wr;
        issue_src      <= 1'b0;
      end else if (grant_gfx) begin
        bus.ram_addr   <= bus.gfx_addr;
        bus.ram_wdata  <= bus.gfx_wdata;
        bus.ram_wena   <= bus.gfx_wr;
        bus.ram_rd_req <= ~bus.gfx_wr;
        bus.gfx_ack    <= 1'b1;
        issue_src      <= 1'b1;
      end

      // Last stage lines up with the cycle ram_rdata is valid.
      tag_valid <= tag_valid_in[RD_LATENCY-1:0];
      tag_src   <= tag_src_in[RD_LATENCY-1:0];

      bus.z80_rd_rdy <= 1'b0;
      bus.gfx_rd_rdy <= 1'b0;
      if (tag_valid[RD_LATENCY-1]) begin
        if (tag_src[RD_LATENCY-1]) begin
          bus.gfx_rData  <= bus.ram_rdata;
          bus.gfx_rd_rdy <= 1'b1;
        end else begin
          bus.z80_rData  <= bus.ram_rdata;
          bus.z80_rd_rdy <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gpu_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_gpu_ram_arbiter : directed stimulus with a queue-based scoreboard monitor.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_gpu_ram_arbiter;
  localparam int AB  = 20;
  localparam int LAT = 2;

  typedef struct {
    int        cyc;
    bit        wr;
    logic [19:0] addr;
    logic [7:0]  wdata;
    bit        ack;
  } ram_exp_t;

  typedef struct {
    int        cyc;
    logic [7:0] data;
  } rd_exp_t;

  logic GPU_CLK = 1'b0;
  logic reset   = 1'b1;
  int   cyc     = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   done    = 1'b0;
  bit   wait_expired = 1'b0;
  int   ovr_from  = 1 << 30;
  int   ovr_until = 1 << 30;

  ram_exp_t ram_q[$];
  rd_exp_t  z80_q[$];
  rd_exp_t  gfx_q[$];
  int       zero_q[$];

  gpu_ram_arbiter_if #(.ADDR_BITS(AB)) bus ();

  gpu_ram_arbiter #(.ADDR_BITS(AB), .RD_LATENCY(LAT)) dut (
    .GPU_CLK (GPU_CLK),
    .reset   (reset),
    .bus     (bus)
  );

  always #4 GPU_CLK = ~GPU_CLK;

  always @(posedge GPU_CLK) cyc <= cyc + 1;

  // RAM model: byte array indexed by the low address bits, fixed read latency.
  logic [7:0] mem [0:255];
  logic [7:0] dl  [0:LAT-1];

  function automatic logic [7:0] init_val(input int k);
    if (k < 4)          return 8'h10 + 8'(k);
    else if (k == 'h10) return 8'h77;
    else if (k == 'h40) return 8'h5C;
    else                return 8'(k);
  endfunction

  always @(posedge GPU_CLK) begin
    if (reset) begin
      for (int k = 0; k < 256; k++) mem[k] <= init_val(k);
    end else if (bus.ram_wena) begin
      mem[bus.ram_addr[7:0]] <= bus.ram_wdata;
    end
    dl[0] <= mem[bus.ram_addr[7:0]];
    for (int i = 1; i < LAT; i++) dl[i] <= dl[i-1];
  end

  assign bus.ram_rdata = dl[LAT-1];

  function automatic void exp_ram(input int c, input bit wr, input logic [19:0] a,
                                  input logic [7:0] d, input bit ack);
    ram_exp_t e;
    e.cyc = c; e.wr = wr; e.addr = a; e.wdata = d; e.ack = ack;
    ram_q.push_back(e);
  endfunction

  function automatic void exp_z80(input int c, input logic [7:0] d);
    rd_exp_t e;
    e.cyc = c; e.data = d;
    z80_q.push_back(e);
  endfunction

  function automatic void exp_gfx(input int c, input logic [7:0] d);
    rd_exp_t e;
    e.cyc = c; e.data = d;
    gfx_q.push_back(e);
  endfunction

  // Monitor / scoreboard
  always @(negedge GPU_CLK) begin
    ram_exp_t er;
    rd_exp_t  ed;
    bit       exp_ovr;
    if (done || cyc > 3000) begin
      if (!done) begin
        vectors++; miscompares++;
        $display("FAIL watchdog: cycle=%0d limit=3000", cyc);
      end
      vectors++;
      if (ram_q.size() != 0) begin
        miscompares++;
        $display("FAIL ram_leftover: outstanding=%0d required=0", ram_q.size());
      end
      vectors++;
      if (z80_q.size() != 0) begin
        miscompares++;
        $display("FAIL z80_rd_leftover: outstanding=%0d required=0", z80_q.size());
      end
      vectors++;
      if (gfx_q.size() != 0) begin
        miscompares++;
        $display("FAIL gfx_rd_leftover: outstanding=%0d required=0", gfx_q.size());
      end
      vectors++;
      if (wait_expired) begin
        miscompares++;
        $display("FAIL gfx_ack_wait: expired=1 required=0");
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
    end else begin
      exp_ovr = (cyc >= ovr_from) && (cyc < ovr_until);
      vectors++;
      if (bus.z80_overrun !== exp_ovr) begin
        miscompares++;
        $display("FAIL z80_overrun: cyc=%0d got=%b required=%b", cyc, bus.z80_overrun, exp_ovr);
      end

      if (zero_q.size() != 0 && zero_q[0] == cyc) begin
        void'(zero_q.pop_front());
        vectors++;
        if ({bus.ram_wena, bus.ram_rd_req, bus.gfx_ack, bus.z80_rd_rdy, bus.gfx_rd_rdy} !== 5'b0 ||
            bus.ram_addr !== '0 || bus.ram_wdata !== 8'h00 ||
            bus.z80_rData !== 8'h00 || bus.gfx_rData !== 8'h00) begin
          miscompares++;
          $display("FAIL reset_zero: cyc=%0d wena=%b rd=%b ack=%b zrdy=%b grdy=%b addr=%h wdata=%h zdata=%h gdata=%h required all 0",
                   cyc, bus.ram_wena, bus.ram_rd_req, bus.gfx_ack, bus.z80_rd_rdy, bus.gfx_rd_rdy,
                   bus.ram_addr, bus.ram_wdata, bus.z80_rData, bus.gfx_rData);
        end
      end

      if (bus.ram_wena === 1'b1 || bus.ram_rd_req === 1'b1) begin
        vectors++;
        if (ram_q.size() == 0) begin
          miscompares++;
          $display("FAIL ram_issue: cyc=%0d unexpected wena=%b rd=%b addr=%h required no access",
                   cyc, bus.ram_wena, bus.ram_rd_req, bus.ram_addr);
        end else begin
          er = ram_q.pop_front();
          if (er.cyc != cyc || bus.ram_wena !== er.wr || bus.ram_rd_req !== !er.wr ||
              bus.ram_addr !== er.addr || (er.wr && bus.ram_wdata !== er.wdata) ||
              bus.gfx_ack !== er.ack) begin
            miscompares++;
            $display("FAIL ram_issue: got cyc=%0d wena=%b rd=%b addr=%h wdata=%h ack=%b required cyc=%0d wr=%b addr=%h wdata=%h ack=%b",
                     cyc, bus.ram_wena, bus.ram_rd_req, bus.ram_addr, bus.ram_wdata, bus.gfx_ack,
                     er.cyc, er.wr, er.addr, er.wdata, er.ack);
          end
        end
      end else if (bus.gfx_ack === 1'b1) begin
        vectors++; miscompares++;
        $display("FAIL gfx_ack: cyc=%0d ack=1 without RAM strobe required 0", cyc);
      end

      if (bus.z80_rd_rdy === 1'b1) begin
        vectors++;
        if (z80_q.size() == 0) begin
          miscompares++;
          $display("FAIL z80_rd: cyc=%0d unexpected data=%h required no pulse", cyc, bus.z80_rData);
        end else begin
          ed = z80_q.pop_front();
          if (ed.cyc != cyc || bus.z80_rData !== ed.data) begin
            miscompares++;
            $display("FAIL z80_rd: got cyc=%0d data=%h required cyc=%0d data=%h",
                     cyc, bus.z80_rData, ed.cyc, ed.data);
          end
        end
      end

      if (bus.gfx_rd_rdy === 1'b1) begin
        vectors++;
        if (gfx_q.size() == 0) begin
          miscompares++;
          $display("FAIL gfx_rd: cyc=%0d unexpected data=%h required no pulse", cyc, bus.gfx_rData);
        end else begin
          ed = gfx_q.pop_front();
          if (ed.cyc != cyc || bus.gfx_rData !== ed.data) begin
            miscompares++;
            $display("FAIL gfx_rd: got cyc=%0d data=%h required cyc=%0d data=%h",
                     cyc, bus.gfx_rData, ed.cyc, ed.data);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge GPU_CLK);
    #1;
  endtask

  task automatic z80_pulse(input bit wr, input bit rd, input logic [19:0] a, input logic [7:0] d);
    bus.z80_wr_ena = wr;
    bus.z80_rd_req = rd;
    bus.z80_addr   = a;
    bus.z80_wdata  = d;
    tick();
    bus.z80_wr_ena = 1'b0;
    bus.z80_rd_req = 1'b0;
  endtask

  // Returns in the cycle gfx_ack is seen high (possibly the current one).
  task automatic wait_ack();
    bit got;
    got = bus.gfx_ack;
    for (int i = 0; i < 12 && !got; i++) begin
      tick();
      got = bus.gfx_ack;
    end
    if (!got) wait_expired = 1'b1;
  endtask

  initial begin
    int t;
    bus.z80_wr_ena = 1'b0;
    bus.z80_rd_req = 1'b0;
    bus.z80_addr   = '0;
    bus.z80_wdata  = '0;
    bus.gfx_req    = 1'b0;
    bus.gfx_wr     = 1'b0;
    bus.gfx_addr   = '0;
    bus.gfx_wdata  = '0;
    zero_q.push_back(1);
    zero_q.push_back(2);
    tick();
    tick();
    reset = 1'b0;
    repeat (2) tick();

    // Z80 write
    t = cyc;
    exp_ram(t + 1, 1'b1, 20'h00123, 8'hA5, 1'b0);
    z80_pulse(1'b1, 1'b0, 20'h00123, 8'hA5);
    repeat (4) tick();

    // Z80 read, data returns at issue + LAT + 1
    t = cyc;
    exp_ram(t + 1, 1'b0, 20'h00040, 8'h00, 1'b0);
    exp_z80(t + LAT + 2, 8'h5C);
    z80_pulse(1'b0, 1'b1, 20'h00040, 8'h00);
    repeat (6) tick();

    // gfx read and Z80 write in the same cycle
    t = cyc;
`ifdef GPU_RAM_ARB_RR_EN
    exp_ram(t + 1, 1'b0, 20'h00010, 8'h00, 1'b1);
    exp_ram(t + 2, 1'b1, 20'h002A5, 8'h3C, 1'b0);
    exp_gfx(t + LAT + 2, 8'h77);
`else
    exp_ram(t + 1, 1'b1, 20'h002A5, 8'h3C, 1'b0);
    exp_ram(t + 2, 1'b0, 20'h00010, 8'h00, 1'b1);
    exp_gfx(t + LAT + 3, 8'h77);
`endif
    bus.gfx_req   = 1'b1;
    bus.gfx_wr    = 1'b0;
    bus.gfx_addr  = 20'h00010;
    bus.gfx_wdata = 8'h00;
    z80_pulse(1'b1, 1'b0, 20'h002A5, 8'h3C);
    wait_ack();
    bus.gfx_req = 1'b0;
    repeat (6) tick();

    // gfx streams four reads, one issue every two cycles
    t = cyc;
    for (int k = 0; k < 4; k++) begin
      exp_ram(t + 1 + 2 * k, 1'b0, 20'(k), 8'h00, 1'b1);
      exp_gfx(t + 2 + LAT + 2 * k, 8'h10 + 8'(k));
    end
    bus.gfx_req  = 1'b1;
    bus.gfx_wr   = 1'b0;
    bus.gfx_addr = 20'h00000;
    for (int k = 0; k < 4; k++) begin
      wait_ack();
      if (k < 3) bus.gfx_addr = 20'(k + 1);
      else       bus.gfx_req  = 1'b0;
      tick();
    end
    repeat (6) tick();

    // Simultaneous write and read pulses: write wins, overrun is sticky
    t = cyc;
    exp_ram(t + 1, 1'b1, 20'h003F0, 8'h99, 1'b0);
    ovr_from = t + 1;
    z80_pulse(1'b1, 1'b1, 20'h003F0, 8'h99);
    repeat (3) tick();
    t = cyc;
    exp_ram(t + 1, 1'b1, 20'h003F1, 8'h66, 1'b0);
    z80_pulse(1'b1, 1'b0, 20'h003F1, 8'h66);
    repeat (3) tick();

    // Reset while a read is in flight: no return pulse, outputs cleared
    t = cyc;
    exp_ram(t + 1, 1'b0, 20'h00040, 8'h00, 1'b0);
    z80_pulse(1'b0, 1'b1, 20'h00040, 8'h00);
    tick();
    reset     = 1'b1;
    ovr_until = t + 3;
    zero_q.push_back(t + 3);
    tick();
    reset = 1'b0;
    repeat (6) tick();

    t = cyc;
    exp_ram(t + 1, 1'b1, 20'h000AB, 8'h5A, 1'b0);
    z80_pulse(1'b1, 1'b0, 20'h000AB, 8'h5A);
    repeat (4) tick();
    done = 1'b1;
  end

endmodule

`default_nettype wire
